obstacle_scheduler: RTL and testbench



---
 rtl/obstacle_pkg.sv | 17 +
 rtl/obstacle_scheduler_lfsr16.sv | 36 +++
 rtl/obstacle_scheduler.sv | 151 +++++++++++++++
 tb/tb_obstacle_scheduler.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/obstacle_pkg.sv
// Shared types and constants for the obstacle scheduler slice.
package obstacle_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARM   = 2'd1,
    WAIT  = 2'd2,
    OFFER = 2'd3
  } state_t;

  typedef logic [1:0] lane_t;
  typedef logic [1:0] kind_t;

  // Galois feedback mask for the 16-bit LFSR (x^16 + x^14 + x^13 + x^11 + 1)
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/obstacle_scheduler_lfsr16.sv
// Step-enabled 16-bit Galois LFSR; OUT_W selects how many low bits are exposed.
module lfsr16
  import obstacle_pkg::*;
#(
  parameter logic [15:0] SEED  = 16'hACE1,
  parameter int unsigned OUT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             step_i,
  output logic [OUT_W-1:0] state_o
);

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  // Advance one Galois step only when requested
  always_comb begin
    lfsr_d = lfsr_q;
    if (step_i) begin
      lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : '0);
    end
  end

  // State register, seeded on reset
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign state_o = lfsr_q[OUT_W-1:0];

endmodule

// File: rtl/obstacle_scheduler.sv
// Decides when the next obstacle spawns: arms the countdown timer with a
// jittered interval, offers a spawn descriptor, and tracks difficulty/drops.
module obstacle_scheduler
  import obstacle_pkg::*;
#(
  parameter logic [3:0]  BASE_INTERVAL    = 4'd8,
  parameter logic [3:0]  MIN_INTERVAL     = 4'd3,
  parameter logic [7:0]  SPAWNS_PER_LEVEL = 8'd8,
  parameter logic [2:0]  MAX_LEVEL        = 3'd7,
  parameter logic [3:0]  STALL_LIMIT      = 4'd5,
  parameter logic [15:0] LFSR_SEED        = 16'hACE1
) (
  input  logic       clk_in,
  input  logic       rst_n_in,
  input  logic       enable_in,
  input  logic       timer_expired_in,
  input  logic       pulse_100ms_in,
  output logic       timer_start_out,
  output logic [3:0] timer_value_out,
  output logic       spawn_valid_out,
  input  logic       spawn_ready_in,
  output logic [1:0] spawn_lane_out,
  output logic [1:0] spawn_kind_out,
  output logic [2:0] level_out,
  output logic [7:0] dropped_out
);

  state_t      state_q, state_d;
  logic [2:0]  level_q, level_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [3:0]  stall_q, stall_d;
  logic [7:0]  dropped_q, dropped_d;
  lane_t       lane_q, lane_d;
  kind_t       kind_q, kind_d;

  logic        lfsr_step;
  logic [5:0]  lfsr;

  logic [4:0]  diff;
  logic [4:0]  base_eff;
  logic [4:0]  sum;
  logic [3:0]  interval;
  logic [7:0]  cnt_inc;
  logic [3:0]  stall_inc;

  lfsr16 #(
    .SEED  (LFSR_SEED),
    .OUT_W (6)
  ) u_lfsr (
    .clk_i   (clk_in),
    .rst_ni  (rst_n_in),
    .step_i  (lfsr_step),
    .state_o (lfsr)
  );

  // Interval: floor(BASE - level) at MIN, add 2-bit jitter, clamp to 15
  always_comb begin
    diff     = {1'b0, BASE_INTERVAL} - {2'b00, level_q};
    base_eff = (diff[4] || (diff < {1'b0, MIN_INTERVAL})) ? {1'b0, MIN_INTERVAL} : diff;
    sum      = base_eff + {3'b000, lfsr[1:0]};
    interval = (sum > 5'd15) ? 4'd15 : sum[3:0];
  end

  // State and datapath registers
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q   <= IDLE;
      level_q   <= '0;
      cnt_q     <= '0;
      stall_q   <= '0;
      dropped_q <= '0;
      lane_q    <= '0;
      kind_q    <= '0;
    end else begin
      state_q   <= state_d;
      level_q   <= level_d;
      cnt_q     <= cnt_d;
      stall_q   <= stall_d;
      dropped_q <= dropped_d;
      lane_q    <= lane_d;
      kind_q    <= kind_d;
    end
  end

  // Next-state and counter updates; enable_in low overrides the transition
  // but an on-wire handshake in that same cycle is still counted.
  always_comb begin
    state_d   = state_q;
    level_d   = level_q;
    cnt_d     = cnt_q;
    stall_d   = stall_q;
    dropped_d = dropped_q;
    lane_d    = lane_q;
    kind_d    = kind_q;
    lfsr_step = 1'b0;
    cnt_inc   = cnt_q + 8'd1;
    stall_inc = stall_q + 4'd1;

    unique case (state_q)
      IDLE: begin
        state_d = ARM;
      end
      ARM: begin
        lfsr_step = 1'b1;
        lane_d    = (lfsr[3:2] == 2'd3) ? 2'd1 : lfsr[3:2];
        kind_d    = lfsr[5:4];
        state_d   = WAIT;
      end
      WAIT: begin
        if (timer_expired_in) begin
          stall_d = '0;
          state_d = OFFER;
        end
      end
      OFFER: begin
        if (spawn_ready_in) begin
          state_d = ARM;
          if (cnt_inc >= SPAWNS_PER_LEVEL) begin
            cnt_d   = '0;
            level_d = (level_q == MAX_LEVEL) ? level_q : level_q + 3'd1;
          end else begin
            cnt_d = cnt_inc;
          end
        end else if (pulse_100ms_in) begin
          stall_d = stall_inc;
          if (stall_inc >= STALL_LIMIT && enable_in) begin
            dropped_d = (dropped_q == 8'hFF) ? dropped_q : dropped_q + 8'd1;
            state_d   = ARM;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (!enable_in) begin
      state_d = IDLE;
    end
  end

  // Outputs decoded from state and registered descriptor/counters
  always_comb begin
    timer_start_out = (state_q == ARM);
    timer_value_out = (state_q == ARM) ? interval : '0;
    spawn_valid_out = (state_q == OFFER);
    spawn_lane_out  = lane_q;
    spawn_kind_out  = kind_q;
    level_out       = level_q;
    dropped_out     = dropped_q;
  end

endmodule

// File: tb/tb_obstacle_scheduler.sv
// Directed self-checking bench for obstacle_scheduler.
module tb_obstacle_scheduler;

  logic       clk_in;
  logic       rst_n_in;
  logic       enable_in;
  logic       timer_expired_in;
  logic       pulse_100ms_in;
  logic       timer_start_out;
  logic [3:0] timer_value_out;
  logic       spawn_valid_out;
  logic       spawn_ready_in;
  logic [1:0] spawn_lane_out;
  logic [1:0] spawn_kind_out;
  logic [2:0] level_out;
  logic [7:0] dropped_out;

  int unsigned n_chk;
  int unsigned n_pass;
  int unsigned n_acc;

  logic [15:0] m_lfsr;
  logic [2:0]  m_level;
  int unsigned m_cnt;
  logic [7:0]  m_dropped;
  logic [1:0]  m_lane;
  logic [1:0]  m_kind;

  obstacle_scheduler dut (
    .clk_in           (clk_in),
    .rst_n_in         (rst_n_in),
    .enable_in        (enable_in),
    .timer_expired_in (timer_expired_in),
    .pulse_100ms_in   (pulse_100ms_in),
    .timer_start_out  (timer_start_out),
    .timer_value_out  (timer_value_out),
    .spawn_valid_out  (spawn_valid_out),
    .spawn_ready_in   (spawn_ready_in),
    .spawn_lane_out   (spawn_lane_out),
    .spawn_kind_out   (spawn_kind_out),
    .level_out        (level_out),
    .dropped_out      (dropped_out)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] m_step(input logic [15:0] r);
    return {1'b0, r[15:1]} ^ (r[0] ? 16'hB400 : 16'h0000);
  endfunction

  function automatic logic [3:0] m_interval(input logic [2:0] lvl, input logic [15:0] r);
    int b;
    b = 8 - int'(lvl);
    if (b < 3) b = 3;
    b = b + int'(r[1:0]);
    if (b > 15) b = 15;
    return 4'(b);
  endfunction

  task automatic m_reset();
    m_lfsr    = 16'hACE1;
    m_level   = 3'd0;
    m_cnt     = 0;
    m_dropped = 8'd0;
  endtask

  task automatic m_accept();
    n_acc++;
    m_cnt++;
    if (m_cnt == 8) begin
      m_cnt = 0;
      if (m_level != 3'd7) m_level = m_level + 3'd1;
    end
  endtask

  // Entered at the negedge while in ARM; leaves at the negedge in WAIT.
  task automatic arm_check(input bit stray);
    logic [1:0] sel;
    check("arm_start", 16'(timer_start_out), 16'd1);
    check("arm_value", 16'(timer_value_out), 16'(m_interval(m_level, m_lfsr)));
    check("arm_floor", 16'(timer_value_out >= 4'd3), 16'd1);
    check("arm_valid", 16'(spawn_valid_out), 16'd0);
    sel    = m_lfsr[3:2];
    m_lane = (sel == 2'd3) ? 2'd1 : sel;
    m_kind = m_lfsr[5:4];
    m_lfsr = m_step(m_lfsr);
    if (stray) timer_expired_in = 1'b1;
    @(negedge clk_in);
    timer_expired_in = 1'b0;
    check("wait_start", 16'(timer_start_out), 16'd0);
    check("wait_valid", 16'(spawn_valid_out), 16'd0);
    check("wait_lane", 16'(spawn_lane_out), 16'(m_lane));
    check("wait_kind", 16'(spawn_kind_out), 16'(m_kind));
  endtask

  task automatic to_offer();
    timer_expired_in = 1'b1;
    @(negedge clk_in);
    timer_expired_in = 1'b0;
    check("offer_valid", 16'(spawn_valid_out), 16'd1);
    check("offer_lane", 16'(spawn_lane_out), 16'(m_lane));
    check("offer_kind", 16'(spawn_kind_out), 16'(m_kind));
  endtask

  task automatic accept();
    spawn_ready_in = 1'b1;
    @(negedge clk_in);
    spawn_ready_in = 1'b0;
    m_accept();
    check("acc_valid", 16'(spawn_valid_out), 16'd0);
    check("acc_level", 16'(level_out), 16'(m_level));
    check("acc_dropped", 16'(dropped_out), 16'(m_dropped));
  endtask

  // Four stall ticks with idle gaps; a stray expiry in OFFER is injected too.
  task automatic four_ticks();
    for (int i = 0; i < 4; i++) begin
      pulse_100ms_in = 1'b1;
      @(negedge clk_in);
      pulse_100ms_in = 1'b0;
      check("stall_valid", 16'(spawn_valid_out), 16'd1);
      if (i == 1) timer_expired_in = 1'b1;
      @(negedge clk_in);
      timer_expired_in = 1'b0;
      check("stall_gap_valid", 16'(spawn_valid_out), 16'd1);
    end
  endtask

  initial begin
    n_chk = 0; n_pass = 0; n_acc = 0;
    rst_n_in = 1'b0; enable_in = 1'b0; timer_expired_in = 1'b0;
    pulse_100ms_in = 1'b0; spawn_ready_in = 1'b0;
    m_reset();
    repeat (2) @(negedge clk_in);
    check("rst_start", 16'(timer_start_out), 16'd0);
    check("rst_value", 16'(timer_value_out), 16'd0);
    check("rst_valid", 16'(spawn_valid_out), 16'd0);
    check("rst_level", 16'(level_out), 16'd0);
    check("rst_dropped", 16'(dropped_out), 16'd0);

    // Stray expiry in IDLE with enable low
    rst_n_in = 1'b1;
    timer_expired_in = 1'b1;
    @(negedge clk_in);
    timer_expired_in = 1'b0;
    check("idle_start", 16'(timer_start_out), 16'd0);
    check("idle_valid", 16'(spawn_valid_out), 16'd0);

    enable_in = 1'b1;
    @(negedge clk_in);
    check("first_value", 16'(timer_value_out), 16'd9);
    arm_check(1'b0);
    check("first_lane", 16'(spawn_lane_out), 16'd0);
    check("first_kind", 16'(spawn_kind_out), 16'd2);
    to_offer();

    // Asynchronous reset in the middle of an offer
    #1 rst_n_in = 1'b0;
    #1;
    check("arst_valid", 16'(spawn_valid_out), 16'd0);
    check("arst_start", 16'(timer_start_out), 16'd0);
    check("arst_lane", 16'(spawn_lane_out), 16'd0);
    check("arst_kind", 16'(spawn_kind_out), 16'd0);
    @(negedge clk_in);
    rst_n_in = 1'b1;
    m_reset();
    @(negedge clk_in);
    check("rearm_value", 16'(timer_value_out), 16'd9);
    arm_check(1'b0);
    to_offer();
    accept();
    check("second_start", 16'(timer_start_out), 16'd1);
    check("second_value", 16'(timer_value_out), 16'd8);
    arm_check(1'b0);
    check("second_lane", 16'(spawn_lane_out), 16'd0);
    check("second_kind", 16'(spawn_kind_out), 16'd3);
    to_offer();
    accept();
    for (int i = 0; i < 6; i++) begin
      arm_check(1'b0);
      to_offer();
      accept();
    end
    check("level_after_8", 16'(level_out), 16'd1);

    // Stalled offer is dropped on the fifth tick
    arm_check(1'b0);
    to_offer();
    four_ticks();
    pulse_100ms_in = 1'b1;
    @(negedge clk_in);
    pulse_100ms_in = 1'b0;
    m_dropped = m_dropped + 8'd1;
    check("drop_valid", 16'(spawn_valid_out), 16'd0);
    check("drop_count", 16'(dropped_out), 16'd1);
    check("drop_level", 16'(level_out), 16'd1);

    // Ready coincident with the limiting tick: acceptance wins
    arm_check(1'b0);
    to_offer();
    four_ticks();
    pulse_100ms_in = 1'b1;
    spawn_ready_in = 1'b1;
    @(negedge clk_in);
    pulse_100ms_in = 1'b0;
    spawn_ready_in = 1'b0;
    m_accept();
    check("coinc_valid", 16'(spawn_valid_out), 16'd0);
    check("coinc_dropped", 16'(dropped_out), 16'd1);
    check("coinc_start", 16'(timer_start_out), 16'd1);

    // Stray expiry in ARM, then enable dropped while in WAIT
    arm_check(1'b1);
    enable_in = 1'b0;
    @(negedge clk_in);
    check("dis_wait_valid", 16'(spawn_valid_out), 16'd0);
    check("dis_wait_start", 16'(timer_start_out), 16'd0);
    timer_expired_in = 1'b1;
    @(negedge clk_in);
    timer_expired_in = 1'b0;
    check("dis_idle_valid", 16'(spawn_valid_out), 16'd0);
    check("dis_idle_level", 16'(level_out), 16'(m_level));
    enable_in = 1'b1;
    @(negedge clk_in);

    // Enable dropped while offering withdraws the offer
    arm_check(1'b0);
    to_offer();
    enable_in = 1'b0;
    @(negedge clk_in);
    check("dis_offer_valid", 16'(spawn_valid_out), 16'd0);
    check("dis_offer_start", 16'(timer_start_out), 16'd0);
    check("dis_offer_level", 16'(level_out), 16'd1);
    check("dis_offer_dropped", 16'(dropped_out), 16'd1);
    enable_in = 1'b1;
    @(negedge clk_in);

    // Drive difficulty to saturation and beyond
    while (n_acc < 72) begin
      arm_check(1'b0);
      to_offer();
      accept();
      if (n_acc == 16) check("level_after_16", 16'(level_out), 16'd2);
      if (n_acc == 64) check("level_after_64", 16'(level_out), 16'd7);
    end
    check("level_saturated", 16'(level_out), 16'd7);
    arm_check(1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
